// File: rtl/logic16_pkg.sv
// Shared opcode and FSM encodings for the shared 16-bit logic unit arbiter.
package logic16_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic16_unit.sv
// Combinational bitwise logic unit: AND / OR / XOR / NAND, no carry.
module logic16_unit
  import logic16_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  // Select the bitwise function by opcode
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one logic16_unit between NREQ requesters,
// with a single registered result slot and valid/ready handshake.
module logic16_arbiter
  import logic16_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   a,
  input  logic [W*NREQ-1:0]   b,
  output logic [NREQ-1:0]     gnt,
  output logic [W-1:0]        out_result,
  output logic [IDW-1:0]      out_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     unit_y;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   win;
  logic [NREQ-1:0]  win_oh;

  // Scan from last+NREQ down to last+1 so the nearest requester after last wins
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int unsigned    idx;
    pick = last;
    for (int unsigned i = NREQ; i > 0; i--) begin
      idx = (32'(last) + i) % NREQ;
      if (r[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  logic16_unit #(.W(W)) u_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (unit_y)
  );

  // Round-robin winner and its one-hot grant vector
  always_comb begin
    win         = rr_pick(req, last_q);
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign busy = (state_q != ST_IDLE);

  // Grant / execute / hold-result sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_id     <= '0;
      last_q     <= IDW'(NREQ - 1);
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      gnt <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            op_q    <= op[2*win +: 2];
            a_q     <= a[W*win +: W];
            b_q     <= b[W*win +: W];
            id_q    <= win;
            last_q  <= win;
            gnt     <= win_oh;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result <= unit_y;
          out_id     <= id_q;
          out_valid  <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
